// File: rtl/time_counter.sv
// Timekeeping core: binary hh:mm:ss advanced once per second by a clock prescaler,
// loadable from the setting block with per-field validation; counting frozen in setting mode.
module time_counter #(
   parameter int unsigned CLK_HZ = 50_000_000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  rezhim,
   input  logic [23:0] setup_data,
   input  logic        setup_imp,
   output logic [23:0] data_ch,
   output logic        sec_pulse,
   output logic        day_pulse,
   output logic        load_ack
);

   localparam int unsigned     PW        = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_HZ - 1);
   localparam logic [1:0]      MODE_SET  = 2'd3;

   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    hh_q, hh_d;
   logic [7:0]    mm_q, mm_d;
   logic [7:0]    ss_q, ss_d;
   logic          setup_imp_q;
   logic          sec_q, sec_d;
   logic          day_q, day_d;
   logic          ack_q, ack_d;

   logic          frozen;
   logic          load;
   logic          tick;

   assign frozen = (rezhim == MODE_SET);
   assign load   = setup_imp & ~setup_imp_q;
   assign tick   = ~frozen & (presc_q == PRESC_MAX);

   // Load has priority over tick; a colliding tick is dropped together with its pulses.
   always_comb begin
      presc_d = presc_q;
      hh_d    = hh_q;
      mm_d    = mm_q;
      ss_d    = ss_q;
      sec_d   = 1'b0;
      day_d   = 1'b0;
      ack_d   = 1'b0;

      if (load) begin
         hh_d    = (setup_data[23:16] > 8'd23) ? '0 : setup_data[23:16];
         mm_d    = (setup_data[15:8]  > 8'd59) ? '0 : setup_data[15:8];
         ss_d    = (setup_data[7:0]   > 8'd59) ? '0 : setup_data[7:0];
         presc_d = '0;
         ack_d   = 1'b1;
      end else if (frozen) begin
         presc_d = '0;
      end else if (tick) begin
         presc_d = '0;
         sec_d   = 1'b1;
         if (ss_q < 8'd59) begin
            ss_d = ss_q + 8'd1;
         end else begin
            ss_d = '0;
            if (mm_q < 8'd59) begin
               mm_d = mm_q + 8'd1;
            end else begin
               mm_d = '0;
               if (hh_q < 8'd23) begin
                  hh_d = hh_q + 8'd1;
               end else begin
                  hh_d  = '0;
                  day_d = 1'b1;
               end
            end
         end
      end else begin
         presc_d = presc_q + PW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         presc_q     <= '0;
         hh_q        <= '0;
         mm_q        <= '0;
         ss_q        <= '0;
         setup_imp_q <= 1'b0;
         sec_q       <= 1'b0;
         day_q       <= 1'b0;
         ack_q       <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         hh_q        <= hh_d;
         mm_q        <= mm_d;
         ss_q        <= ss_d;
         setup_imp_q <= setup_imp;
         sec_q       <= sec_d;
         day_q       <= day_d;
         ack_q       <= ack_d;
      end
   end

   assign data_ch   = {hh_q, mm_q, ss_q};
   assign sec_pulse = sec_q;
   assign day_pulse = day_q;
   assign load_ack  = ack_q;

endmodule

// File: tb/tb_time_counter.sv
// Directed self-checking bench for time_counter with CLK_HZ=4.
module tb_time_counter;

   logic        clock;
   logic        reset;
   logic [1:0]  rezhim;
   logic [23:0] setup_data;
   logic        setup_imp;
   logic [23:0] data_ch;
   logic        sec_pulse;
   logic        day_pulse;
   logic        load_ack;

   int unsigned n_tests;
   int unsigned n_fail;

   time_counter #(.CLK_HZ(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .rezhim     (rezhim),
      .setup_data (setup_data),
      .setup_imp  (setup_imp),
      .data_ch    (data_ch),
      .sec_pulse  (sec_pulse),
      .day_pulse  (day_pulse),
      .load_ack   (load_ack)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance n rising edges, leaving time 1 unit past the last edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   int unsigned cnt;
   int unsigned gap;

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      reset      = 1'b1;
      rezhim     = 2'd0;
      setup_data = '0;
      setup_imp  = 1'b0;

      // reset state
      #1 reset = 1'b0;
      #2;
      check("rst_data", {8'd0, data_ch}, 32'h0);
      check("rst_sec", {31'd0, sec_pulse}, 32'd0);
      check("rst_day", {31'd0, day_pulse}, 32'd0);
      check("rst_ack", {31'd0, load_ack}, 32'd0);
      #9 reset = 1'b1;

      // count and carry: first pulse on the 4th edge after release
      step(3);
      check("cnt_pre_sec", {31'd0, sec_pulse}, 32'd0);
      check("cnt_pre_data", {8'd0, data_ch}, 32'h0);
      step(1);
      check("cnt_first_sec", {31'd0, sec_pulse}, 32'd1);
      check("cnt_first_data", {8'd0, data_ch}, 32'h000001);
      step(1);
      check("cnt_sec_low", {31'd0, sec_pulse}, 32'd0);
      cnt = 0;
      gap = 1;
      for (int i = 0; i < 239; i++) begin
         step(1);
         gap++;
         if (sec_pulse) begin
            cnt++;
            check("cnt_gap", gap, 32'd4);
            gap = 0;
         end
      end
      check("cnt_pulses", cnt, 32'd60);
      check("cnt_data", {8'd0, data_ch}, 32'h000101);

      // day wrap
      setup_data = 24'h173B3B;
      setup_imp  = 1'b1;
      step(1);
      setup_imp  = 1'b0;
      check("wrap_load", {8'd0, data_ch}, 32'h173B3B);
      check("wrap_ack", {31'd0, load_ack}, 32'd1);
      step(3);
      check("wrap_pre_day", {31'd0, day_pulse}, 32'd0);
      check("wrap_pre_data", {8'd0, data_ch}, 32'h173B3B);
      step(1);
      check("wrap_data", {8'd0, data_ch}, 32'h000000);
      check("wrap_day", {31'd0, day_pulse}, 32'd1);
      check("wrap_sec", {31'd0, sec_pulse}, 32'd1);
      step(1);
      check("wrap_day_low", {31'd0, day_pulse}, 32'd0);
      check("wrap_sec_low", {31'd0, sec_pulse}, 32'd0);

      // validation with strobe held high
      setup_data = 24'h183C05;
      setup_imp  = 1'b1;
      step(1);
      check("val_data", {8'd0, data_ch}, 32'h000005);
      cnt = 1;
      check("val_ack", {31'd0, load_ack}, 32'd1);
      for (int i = 0; i < 9; i++) begin
         step(1);
         if (load_ack) cnt++;
      end
      check("val_ack_count", cnt, 32'd1);
      setup_imp = 1'b0;
      step(1);

      // freeze, including a load accepted in setting mode
      setup_data = 24'h010203;
      setup_imp  = 1'b1;
      step(1);
      setup_imp  = 1'b0;
      rezhim     = 2'd3;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (sec_pulse) cnt++;
      end
      check("frz_pulses", cnt, 32'd0);
      check("frz_data", {8'd0, data_ch}, 32'h010203);
      setup_data = 24'h020304;
      setup_imp  = 1'b1;
      step(1);
      setup_imp  = 1'b0;
      check("frz_load", {8'd0, data_ch}, 32'h020304);
      check("frz_ack", {31'd0, load_ack}, 32'd1);
      rezhim = 2'd0;
      step(3);
      check("frz_pre_sec", {31'd0, sec_pulse}, 32'd0);
      step(1);
      check("frz_sec", {31'd0, sec_pulse}, 32'd1);
      check("frz_resume", {8'd0, data_ch}, 32'h020305);

      // load/tick collision: prescaler reaches 3 after three more edges
      step(3);
      setup_data = 24'h0A0B0C;
      setup_imp  = 1'b1;
      step(1);
      setup_imp  = 1'b0;
      check("col_data", {8'd0, data_ch}, 32'h0A0B0C);
      check("col_sec", {31'd0, sec_pulse}, 32'd0);
      check("col_ack", {31'd0, load_ack}, 32'd1);
      step(3);
      check("col_pre_sec", {31'd0, sec_pulse}, 32'd0);
      step(1);
      check("col_next_sec", {31'd0, sec_pulse}, 32'd1);
      check("col_next_data", {8'd0, data_ch}, 32'h0A0B0D);

      // back-to-back loads 1,0,1
      setup_data = 24'h0C0D0E;
      setup_imp  = 1'b1;
      step(1);
      check("b2b_first", {8'd0, data_ch}, 32'h0C0D0E);
      check("b2b_ack1", {31'd0, load_ack}, 32'd1);
      setup_imp  = 1'b0;
      setup_data = 24'h112233;
      step(1);
      check("b2b_gap_ack", {31'd0, load_ack}, 32'd0);
      setup_imp = 1'b1;
      step(1);
      setup_imp = 1'b0;
      check("b2b_second", {8'd0, data_ch}, 32'h112233);
      check("b2b_ack2", {31'd0, load_ack}, 32'd1);

      // async reset mid-count at 00:00:07, prescaler=2
      setup_data = 24'h000007;
      setup_imp  = 1'b1;
      step(1);
      setup_imp  = 1'b0;
      step(2);
      reset = 1'b0;
      #3;
      check("arst_data", {8'd0, data_ch}, 32'h0);
      check("arst_sec", {31'd0, sec_pulse}, 32'd0);
      check("arst_day", {31'd0, day_pulse}, 32'd0);
      check("arst_ack", {31'd0, load_ack}, 32'd0);
      #2 reset = 1'b1;
      step(3);
      check("arst_pre_sec", {31'd0, sec_pulse}, 32'd0);
      step(1);
      check("arst_sec_first", {31'd0, sec_pulse}, 32'd1);
      check("arst_data_first", {8'd0, data_ch}, 32'h000001);

      // strobe high across reset release loads on first edge
      setup_data = 24'h030405;
      setup_imp  = 1'b1;
      reset      = 1'b0;
      #3 reset   = 1'b1;
      step(1);
      setup_imp  = 1'b0;
      check("rel_load", {8'd0, data_ch}, 32'h030405);
      check("rel_ack", {31'd0, load_ack}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, expected finish before 100000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/time_counter.md
# time_counter

Timekeeping core of the clock. Holds current time as binary hours/minutes/seconds, advances it once per second from a clock-derived prescaler, and publishes it as `data_ch` to the display path and the setting block. It receives the setting block's output (`setup_data` plus `setup_imp` strobe), validates each field, and loads it as the new current time. Counting is frozen while the user is in setting mode.

## Interface
- `CLK_HZ`, 50_000_000, clock cycles per second; prescaler modulus. Must be ≥ 2.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `rezhim`  in  2  mode select; value 3 = setting mode, counting frozen.
- `setup_data`  in  24  time to load: [23:16] hours, [15:8] minutes, [7:0] seconds, binary.
- `setup_imp`  in  1  load strobe, synchronous to `clock`, may stay high for many cycles.
- `data_ch`  out  24  current time, same field layout as `setup_data`.
- `sec_pulse`  out  1  one-cycle pulse when `data_ch` advances by one second.
- `day_pulse`  out  1  one-cycle pulse when time wraps 23:59:59 → 00:00:00.
- `load_ack`  out  1  one-cycle pulse when a load has taken effect.

## Operation
- Reset (async, `reset`=0): `data_ch`=0 (00:00:00), prescaler=0, `setup_imp_d`=0, `sec_pulse`=`day_pulse`=`load_ack`=0.
- Prescaler: counts 0..CLK_HZ-1, wraps to 0. A tick occurs on the edge where prescaler = CLK_HZ-1 and `rezhim` ≠ 3.
- Freeze: while `rezhim` = 3, prescaler is held at 0 and no ticks occur. On leaving mode 3, the first tick comes after a full CLK_HZ cycles.
- Tick arithmetic, per field (8-bit binary):
  - seconds < 59 → +1; else seconds=0 and carry to minutes.
  - minutes < 59 → +1; else minutes=0 and carry to hours.
  - hours < 23 → +1; else hours=0 and `day_pulse`.
- Load detect: register `setup_imp_d` ← `setup_imp` every cycle. A load fires on the edge where `setup_imp`=1 and `setup_imp_d`=0 (rising edge only). A strobe held high loads once. A strobe high at the first edge after reset loads.
- Load validation, per field: seconds > 59 → 0; minutes > 59 → 0; hours > 23 → 0. In-range fields are copied unchanged.
- A load clears the prescaler to 0 and pulses `load_ack`.
- Loads are accepted in every `rezhim`, including 3.
- Priority: load beats tick on the same edge. The tick is discarded, so there is no `sec_pulse` and no `day_pulse`.
- Fields never hold out-of-range values. Upper unused codes are unreachable.

## Timing
- Tick latency: `data_ch` shows the new value in the cycle after the prescaler = CLK_HZ-1 edge. `sec_pulse` is registered and high in that same cycle, aligned with the new value.
- Tick period: exactly CLK_HZ cycles between consecutive `sec_pulse`.
- `day_pulse`: coincides with the `sec_pulse` of the wrap to 00:00:00.
- Load latency: 1 cycle.
  - Edge N samples `setup_imp` rising.
  - In cycle N+1, `data_ch` holds the validated value and `load_ack`=1.
  - The next tick is CLK_HZ cycles after edge N.
- Back-to-back loads: `setup_imp` 1,0,1 on consecutive cycles gives two loads and two `load_ack` pulses; the second value wins.
- Reset mid-second or mid-load: all state returns to reset values immediately (async). A strobe high during reset release is treated as a rising edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use CLK_HZ=4.
- Count and carry: reset, `rezhim`=0, run 4×61 cycles → `data_ch`=0x00_01_01 (00:01:01). `sec_pulse` every 4 cycles; first pulse in cycle 5 after reset release.
- Day wrap: load 0x17_3B_3B (23:59:59), wait 4 cycles → `data_ch`=0x00_00_00. `day_pulse` and `sec_pulse` both high for exactly 1 cycle.
- Load validation and hold: `setup_data`=0x18_3C_05 (24:60:05), `setup_imp` held high 10 cycles → `data_ch`=0x00_00_05 one cycle after the rise. `load_ack` pulses once only.
- Freeze: `rezhim`=3 for 20 cycles → `data_ch` unchanged and no `sec_pulse`. Set `rezhim`=0 → first `sec_pulse` exactly 4 cycles later.
- Load/tick collision: raise `setup_imp` on the prescaler = 3 edge with `setup_data`=0x0A_0B_0C → `data_ch`=0x0A_0B_0C, not 0x0A_0B_0D. No `sec_pulse` that cycle; next `sec_pulse` 4 cycles later.
- Async reset mid-count: at 00:00:07 with prescaler=2, pulse `reset` low for half a cycle → all outputs 0 immediately. Counting restarts with first `sec_pulse` 4 cycles after release.
